// File: rtl/mup_int_core_if.sv
// Bus bundle for mup_int_core: run/irq inputs, instruction port, status.
// master = core side, slave = environment (ROM, irq source, monitor).
interface mup_int_core_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic          en;
  logic          intr;
  logic [AW-1:0] imem_addr;
  logic [DW+3:0] imem_data;
  logic          int_ack;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          halted;

  modport master (
    input  en, intr, imem_data,
    output imem_addr, int_ack, out_data, out_valid, halted
  );

  modport slave (
    output en, intr, imem_data,
    input  imem_addr, int_ack, out_data, out_valid, halted
  );
endinterface

// File: rtl/mup_int_core.sv
// mup_int_core: accumulator CPU, FETCH/DECODE/EXEC FSM, 1-level interrupt.
// Ports: clk, rst_n (async low), bus (master): en, intr (level irq),
//   imem_addr/imem_data (comb ROM), int_ack, out_data/out_valid, halted.
// Option: define MUP_HALT_WAKE_EN to let intr wake the core from HALT.
module mup_int_core #(
  parameter int            AW      = 8,
  parameter int            DW      = 8,
  parameter logic [AW-1:0] RST_VEC = 'h00,
  parameter logic [AW-1:0] ISR_VEC = 'hF0
) (
  input  logic             clk,
  input  logic             rst_n,
  mup_int_core_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, INTR, HALT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] pc;
  logic [AW-1:0] epc;
  logic [DW+3:0] ir;
  logic [3:0]    dcop;
  logic [DW-1:0] acc;
  logic          z;
  logic          c;
  logic          ie;
  logic          sz;
  logic          sc;
  logic [DW-1:0] out_q;
  logic          ov_q;

  logic [DW-1:0] imm;
  logic [AW-1:0] tgt;
  logic [DW:0]   add_r;
  logic [DW:0]   sub_r;
  logic [DW-1:0] alu_acc;
  logic          alu_c;
  logic          alu_wr;
  logic          jmp;
  logic          take_int;

  assign imm      = ir[DW-1:0];
  assign tgt      = AW'(imm);
  assign add_r    = {1'b0, acc} + {1'b0, imm};
  // top bit of the widened difference is the borrow
  assign sub_r    = {1'b0, acc} - {1'b0, imm};
  assign take_int = bus.intr && ie;
  assign jmp      = (dcop == 4'h7)
                 || ((dcop == 4'h8) && z)
                 || ((dcop == 4'h9) && c);

  always_comb begin
    alu_acc = acc;
    alu_c   = c;
    alu_wr  = 1'b0;
    case (dcop)
      4'h1: begin alu_acc = imm; alu_wr = 1'b1; end
      4'h2: begin {alu_c, alu_acc} = add_r; alu_wr = 1'b1; end
      4'h3: begin {alu_c, alu_acc} = sub_r; alu_wr = 1'b1; end
      4'h4: begin alu_acc = acc & imm; alu_wr = 1'b1; end
      4'h5: begin alu_acc = acc | imm; alu_wr = 1'b1; end
      4'h6: begin alu_acc = acc ^ imm; alu_wr = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // interrupt wins over both HALT entry and an en=0 stall
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (bus.en) state_nx = FETCH;
      FETCH:  state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC: begin
        if (take_int)            state_nx = INTR;
        else if (dcop == 4'hE)   state_nx = HALT;
        else if (bus.en)         state_nx = FETCH;
        else                     state_nx = IDLE;
      end
      INTR:   state_nx = FETCH;
      HALT: begin
`ifdef MUP_HALT_WAKE_EN
        if (bus.intr) state_nx = INTR;
`else
        state_nx = HALT;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RST_VEC;
      epc   <= '0;
      ir    <= '0;
      dcop  <= '0;
      acc   <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
      ie    <= 1'b0;
      sz    <= 1'b0;
      sc    <= 1'b0;
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      unique case (state)
        FETCH: begin
          ir <= bus.imem_data;
          pc <= pc + AW'(1);
        end
        DECODE: dcop <= ir[DW+3 -: 4];
        EXEC: begin
          if (alu_wr) begin
            acc <= alu_acc;
            c   <= alu_c;
            z   <= (alu_acc == '0);
          end
          if (jmp) pc <= tgt;
          if (dcop == 4'hA) ie <= 1'b1;
          if (dcop == 4'hB) ie <= 1'b0;
          if (dcop == 4'hC) begin
            pc <= epc;
            z  <= sz;
            c  <= sc;
            ie <= 1'b1;
          end
          if (dcop == 4'hD) begin
            out_q <= acc;
            ov_q  <= 1'b1;
          end
        end
        INTR: begin
          epc <= pc;
          sz  <= z;
          sc  <= c;
          ie  <= 1'b0;
          pc  <= ISR_VEC;
        end
        IDLE, HALT: ;
        default: ;
      endcase
    end
  end

  assign bus.imem_addr = pc;
  assign bus.int_ack   = (state == INTR);
  assign bus.halted    = (state == HALT);
  assign bus.out_data  = out_q;
  assign bus.out_valid = ov_q;

endmodule
